// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - FETCH/DECODE/EXEC sequencer owning pc and ir, with a bounded memory wait
module fetch_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int INSTR_W      = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               decode_en,
    output logic               exec_en,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               fault
);

    localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc_r;
    logic [INSTR_W-1:0] ir_r;
    logic [CNT_W-1:0]   wait_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            pc_r     <= '0;
            ir_r     <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_r     <= imem_rdata;
                        wait_cnt <= '0;
                        state    <= S_DECODE;
                    end else begin
                        // wait_cnt holds the number of unanswered cycles before this one
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (MEM_WAIT_MAX != 0 && wait_cnt == WAIT_LAST) state <= S_FAULT;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (exec_done) begin
                        pc_r  <= branch_taken ? branch_target : pc_r + ADDR_W'(1);
                        state <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs: decoded from the state register alone
    assign imem_req  = (state == S_FETCH);
    assign decode_en = (state == S_DECODE);
    assign exec_en   = (state == S_EXEC);
    assign busy      = (state != S_IDLE);
    assign fault     = (state == S_FAULT);
    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign ir        = ir_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - vector table, corner sequences and random model check for fetch_sequencer
module tb_fetch_sequencer;

    localparam int AW   = 8;
    localparam int IW   = 32;
    localparam int WMAX = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          run = 1'b0;
    logic          imem_ready = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          exec_done = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          imem_req, decode_en, exec_en, busy, fault;
    logic [AW-1:0] imem_addr, pc;
    logic [IW-1:0] ir;

    fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .MEM_WAIT_MAX(WMAX)) dut (
        .CLK(CLK), .RST_N(RST_N), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ir(ir), .decode_en(decode_en), .exec_en(exec_en), .exec_done(exec_done),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .busy(busy), .fault(fault)
    );

    always #5 CLK = ~CLK;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef logic [52:0] obs_t;

    typedef struct {
        logic          run, rdy;
        logic [IW-1:0] rdata;
        logic          done, bt;
        logic [AW-1:0] tgt;
        logic          req, dec, ex, bsy;
        logic [AW-1:0] pc;
        logic [IW-1:0] ir;
    } vec_t;

    vec_t tbl[$];

    function automatic obs_t dut_obs();
        return {imem_req, imem_addr, decode_en, exec_en, busy, fault, pc, ir};
    endfunction

    function automatic obs_t exp_obs(input logic req, dec, ex, bsy, flt,
                                     input logic [AW-1:0] p, input logic [IW-1:0] i);
        return {req, p, dec, ex, bsy, flt, p, i};
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got {req,addr,dec,ex,busy,fault,pc,ir}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, rdy, input logic [IW-1:0] d, input logic dn, b,
                         input logic [AW-1:0] t);
        run = r; imem_ready = rdy; imem_rdata = d;
        exec_done = dn; branch_taken = b; branch_target = t;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic r, rdy, input logic [IW-1:0] d, input logic dn, b,
                       input logic [AW-1:0] t, input logic req, dec, ex, bsy,
                       input logic [AW-1:0] p, input logic [IW-1:0] i);
        vec_t v;
        v.run = r; v.rdy = rdy; v.rdata = d; v.done = dn; v.bt = b; v.tgt = t;
        v.req = req; v.dec = dec; v.ex = ex; v.bsy = bsy; v.pc = p; v.ir = i;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic          m_req, m_dec, m_ex, m_bsy, m_flt;
        logic [AW-1:0] m_pc;
        logic [IW-1:0] m_ir;
        int            m_fetch_cycle;
        logic          n_req, n_dec, n_ex, n_bsy, n_flt;
        logic [AW-1:0] n_pc;
        logic [IW-1:0] n_ir;
        logic          r_run, r_rdy, r_done, r_bt;
        logic [IW-1:0] r_data;
        logic [AW-1:0] r_tgt;

        // run,rdy,rdata,done,bt,tgt -> req,dec,ex,busy,pc,ir after the edge
        add(1, 1, 32'h0,  1, 0, 8'h00, 1, 0, 0, 1, 8'h00, 32'h0);
        add(1, 1, 32'h0,  1, 1, 8'h77, 0, 1, 0, 1, 8'h00, 32'h0);
        add(1, 1, 32'hAA, 1, 1, 8'h77, 0, 0, 1, 1, 8'h00, 32'h0);
        add(1, 0, 32'h0,  1, 0, 8'h00, 1, 0, 0, 1, 8'h01, 32'h0);
        add(1, 1, 32'h1,  0, 0, 8'h00, 0, 1, 0, 1, 8'h01, 32'h1);
        add(1, 1, 32'hBB, 0, 0, 8'h00, 0, 0, 1, 1, 8'h01, 32'h1);
        add(1, 0, 32'h0,  1, 0, 8'h00, 1, 0, 0, 1, 8'h02, 32'h1);
        add(1, 1, 32'h2,  0, 0, 8'h00, 0, 1, 0, 1, 8'h02, 32'h2);
        add(1, 1, 32'hCC, 0, 0, 8'h00, 0, 0, 1, 1, 8'h02, 32'h2);
        add(1, 0, 32'h0,  1, 1, 8'h05, 1, 0, 0, 1, 8'h05, 32'h2);
        add(1, 0, 32'hDD, 0, 0, 8'h00, 1, 0, 0, 1, 8'h05, 32'h2);
        add(1, 1, 32'h5,  0, 0, 8'h00, 0, 1, 0, 1, 8'h05, 32'h5);
        add(1, 1, 32'hEE, 0, 0, 8'h00, 0, 0, 1, 1, 8'h05, 32'h5);
        add(1, 1, 32'h0,  0, 1, 8'h99, 0, 0, 1, 1, 8'h05, 32'h5);
        add(1, 0, 32'h0,  1, 1, 8'h40, 1, 0, 0, 1, 8'h40, 32'h5);
        add(1, 1, 32'h40, 0, 0, 8'h00, 0, 1, 0, 1, 8'h40, 32'h40);
        add(1, 1, 32'h0,  0, 0, 8'h00, 0, 0, 1, 1, 8'h40, 32'h40);
        add(1, 0, 32'h0,  1, 0, 8'h33, 1, 0, 0, 1, 8'h41, 32'h40);

        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("reset_state", dut_obs(), exp_obs(0, 0, 0, 0, 0, 8'h00, 32'h0));
        RST_N = 1'b1;
        tick();
        chk("idle_no_run", dut_obs(), exp_obs(0, 0, 0, 0, 0, 8'h00, 32'h0));

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].run, tbl[k].rdy, tbl[k].rdata, tbl[k].done, tbl[k].bt, tbl[k].tgt);
            tick();
            chk($sformatf("tbl%0d", k), dut_obs(),
                exp_obs(tbl[k].req, tbl[k].dec, tbl[k].ex, tbl[k].bsy, 1'b0, tbl[k].pc, tbl[k].ir));
        end

        // T1: async reset while in EXEC at pc=0x12
        drive(1, 1, 32'h0, 0, 0, 0); tick(); tick();
        drive(1, 0, 32'h0, 1, 1, 8'h12); tick();
        drive(1, 1, 32'hDEAD, 0, 0, 0); tick();
        drive(1, 0, 32'h0, 0, 0, 0); tick();
        chk("t1_exec_pc12", dut_obs(), exp_obs(0, 0, 1, 1, 0, 8'h12, 32'hDEAD));
        #2 RST_N = 1'b0;
        #1 chk("t1_async_reset", dut_obs(), exp_obs(0, 0, 0, 0, 0, 8'h00, 32'h0));

        // reset mid-FETCH drops the request; a late response is ignored
        tick();
        RST_N = 1'b1;
        drive(1, 0, 32'h0, 0, 0, 0); tick();
        chk("fetch_before_reset", dut_obs(), exp_obs(1, 0, 0, 1, 0, 8'h00, 32'h0));
        #2 RST_N = 1'b0;
        drive(0, 1, 32'hBAD, 0, 0, 0);
        #1 chk("reset_drops_req", dut_obs(), exp_obs(0, 0, 0, 0, 0, 8'h00, 32'h0));
        tick();
        RST_N = 1'b1;
        tick();
        chk("late_resp_ignored", dut_obs(), exp_obs(0, 0, 0, 0, 0, 8'h00, 32'h0));

        // T5a: ready on the 4th FETCH cycle is accepted
        drive(1, 0, 32'h0, 0, 0, 0); tick();
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("t5a_wait%0d", c), dut_obs(), exp_obs(1, 0, 0, 1, 0, 8'h00, 32'h0));
        end
        drive(1, 1, 32'h1234, 0, 0, 0); tick();
        chk("t5a_accept_last", dut_obs(), exp_obs(0, 1, 0, 1, 0, 8'h00, 32'h1234));

        // T4: wrap from 0xFF to 0x00
        tick();
        drive(1, 0, 32'h0, 1, 1, 8'hFF); tick();
        drive(1, 1, 32'h7, 0, 0, 0); tick(); tick();
        drive(1, 0, 32'h0, 1, 0, 8'h10); tick();
        chk("t4_wrap", dut_obs(), exp_obs(1, 0, 0, 1, 0, 8'h00, 32'h7));

        // T5b: no ready for 4 FETCH cycles -> sticky fault
        drive(1, 0, 32'h0, 0, 0, 0);
        tick(); tick(); tick();
        chk("t5b_cycle4_no_fault", dut_obs(), exp_obs(1, 0, 0, 1, 0, 8'h00, 32'h7));
        tick();
        chk("t5b_fault", dut_obs(), exp_obs(0, 0, 0, 1, 1, 8'h00, 32'h7));
        drive(1, 1, 32'h99, 1, 1, 8'h20);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t5b_sticky%0d", c), dut_obs(), exp_obs(0, 0, 0, 1, 1, 8'h00, 32'h7));
        end

        // T6: run drops during a 5-cycle EXEC
        RST_N = 1'b0; #2 RST_N = 1'b1;
        drive(1, 0, 32'h0, 0, 0, 0); tick();
        drive(1, 1, 32'h66, 0, 0, 0); tick(); tick();
        drive(0, 0, 32'h0, 0, 0, 0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("t6_exec%0d", c), dut_obs(), exp_obs(0, 0, 1, 1, 0, 8'h00, 32'h66));
        end
        drive(0, 0, 32'h0, 1, 0, 0); tick();
        chk("t6_stop_idle", dut_obs(), exp_obs(0, 0, 0, 0, 0, 8'h01, 32'h66));
        drive(0, 1, 32'h0, 1, 1, 8'h50);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t6_stay_idle%0d", c), dut_obs(), exp_obs(0, 0, 0, 0, 0, 8'h01, 32'h66));
        end

        // Randomised run against an observation-level model
        RST_N = 1'b0; #2 RST_N = 1'b1;
        m_req = 0; m_dec = 0; m_ex = 0; m_bsy = 0; m_flt = 0;
        m_pc = '0; m_ir = '0; m_fetch_cycle = 0;
        for (int it = 0; it < 2000; it++) begin
            r_run  = ($urandom_range(0, 9) != 0);
            r_rdy  = ($urandom_range(0, 9) < 6);
            r_data = $urandom;
            r_done = ($urandom_range(0, 2) == 0);
            r_bt   = $urandom_range(0, 1);
            r_tgt  = AW'($urandom_range(0, 255));
            drive(r_run, r_rdy, r_data, r_done, r_bt, r_tgt);

            n_req = 0; n_dec = 0; n_ex = 0; n_bsy = 1; n_flt = 0;
            n_pc = m_pc; n_ir = m_ir;
            if (m_flt) begin
                n_flt = 1;
            end else if (m_req) begin
                if (r_rdy) begin
                    n_ir = r_data; n_dec = 1;
                end else if (m_fetch_cycle == WMAX + 1) begin
                    n_flt = 1;
                end else begin
                    n_req = 1; m_fetch_cycle++;
                end
            end else if (m_dec) begin
                n_ex = 1;
            end else if (m_ex) begin
                if (r_done) begin
                    n_pc = r_bt ? r_tgt : AW'((int'(m_pc) + 1) % 256);
                    n_req = r_run; n_bsy = r_run; m_fetch_cycle = 1;
                end else begin
                    n_ex = 1;
                end
            end else begin
                n_req = r_run; n_bsy = r_run; m_fetch_cycle = 1;
            end

            tick();
            chk("random", dut_obs(), exp_obs(n_req, n_dec, n_ex, n_bsy, n_flt, n_pc, n_ir));
            m_req = n_req; m_dec = n_dec; m_ex = n_ex; m_bsy = n_bsy; m_flt = n_flt;
            m_pc = n_pc; m_ir = n_ir;

            if (m_flt && $urandom_range(0, 3) == 0) begin
                RST_N = 1'b0; #1 RST_N = 1'b1;
                m_req = 0; m_dec = 0; m_ex = 0; m_bsy = 0; m_flt = 0;
                m_pc = '0; m_ir = '0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
